// File: rtl/tv80_bus_arbiter_if.sv
// Bus bundle between the tv80s core, the DMA requester and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface tv80_bus_arbiter_if;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_a;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_io;
  logic [15:0] bus_a;
  logic [7:0]  bus_wdata;
  logic        bus_mem_we;
  logic        bus_io_we;
  logic        bus_io_sel;
  logic        burst_abort;

  modport slave (
    output cpu_busrq_n, dma_gnt, bus_a, bus_wdata, bus_mem_we, bus_io_we,
           bus_io_sel, burst_abort,
    input  cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n,
           cpu_wr_n, dma_req, dma_a, dma_wdata, dma_we, dma_io
  );

  modport master (
    input  cpu_busrq_n, dma_gnt, bus_a, bus_wdata, bus_mem_we, bus_io_we,
           bus_io_sel, burst_abort,
    output cpu_busak_n, cpu_a, cpu_do, cpu_mreq_n, cpu_iorq_n, cpu_rd_n,
           cpu_wr_n, dma_req, dma_a, dma_wdata, dma_we, dma_io
  );
endinterface

// File: rtl/tv80_bus_arbiter.sv
// BUSRQ/BUSAK arbiter sharing the tv80s memory/IO bus with one DMA requester.
// Define BUSARB_BURST_LIMIT_EN to bound each tenure to MAX_BURST cycles followed by HOLDOFF idle cycles.
module tv80_bus_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned HOLDOFF   = 8
) (
  input  logic              clk,
  input  logic              reset,
  tv80_bus_arbiter_if.slave bus
);

  localparam logic [2:0] S_CPU  = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_DMA  = 3'd2;
  localparam logic [2:0] S_REL  = 3'd3;
`ifdef BUSARB_BURST_LIMIT_EN
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam int unsigned CW = (MAX_BURST > HOLDOFF) ? $clog2(MAX_BURST + 1)
                                                     : $clog2(HOLDOFF + 1);
`endif

  logic [2:0] state_q, state_d;
  logic       busrq_n_q, busrq_n_d;
  logic       gnt_q, gnt_d;
`ifdef BUSARB_BURST_LIMIT_EN
  // One counter serves both DMA tenure length and HOLD idle time; the states are exclusive.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          forced_q, forced_d;
  logic          abort_q, abort_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef BUSARB_BURST_LIMIT_EN
    cnt_d    = '0;
    forced_d = forced_q;
    abort_d  = 1'b0;
`endif
    case (state_q)
      S_CPU: if (bus.dma_req) state_d = S_REQ;
      S_REQ: begin
        // Withdrawal beats a same-edge acknowledge.
        if (!bus.dma_req)          state_d = S_REL;
        else if (!bus.cpu_busak_n) state_d = S_DMA;
      end
      S_DMA: begin
        if (!bus.dma_req) begin
          state_d = S_REL;
        end
`ifdef BUSARB_BURST_LIMIT_EN
        else if (cnt_q == CW'(MAX_BURST - 1)) begin
          state_d  = S_REL;
          forced_d = 1'b1;
          abort_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_REL: begin
        if (bus.cpu_busak_n) begin
`ifdef BUSARB_BURST_LIMIT_EN
          state_d  = forced_q ? S_HOLD : S_CPU;
          forced_d = 1'b0;
`else
          state_d = S_CPU;
`endif
        end
      end
`ifdef BUSARB_BURST_LIMIT_EN
      S_HOLD: begin
        if (cnt_q == CW'(HOLDOFF - 1)) state_d = S_CPU;
        else                           cnt_d   = cnt_q + 1'b1;
      end
`endif
      default: state_d = S_CPU;
    endcase
    busrq_n_d = !((state_d == S_REQ) || (state_d == S_DMA));
    gnt_d     = (state_d == S_DMA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CPU;
      busrq_n_q <= 1'b1;
      gnt_q     <= 1'b0;
`ifdef BUSARB_BURST_LIMIT_EN
      cnt_q     <= '0;
      forced_q  <= 1'b0;
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busrq_n_q <= busrq_n_d;
      gnt_q     <= gnt_d;
`ifdef BUSARB_BURST_LIMIT_EN
      cnt_q     <= cnt_d;
      forced_q  <= forced_d;
      abort_q   <= abort_d;
`endif
    end
  end

  assign bus.cpu_busrq_n = busrq_n_q;
  assign bus.dma_gnt     = gnt_q;
`ifdef BUSARB_BURST_LIMIT_EN
  assign bus.burst_abort = abort_q;
`else
  assign bus.burst_abort = 1'b0;
`endif

  // Strobes are suppressed while handing back the bus and on any reset cycle.
  always_comb begin
    if (gnt_q) begin
      bus.bus_a      = bus.dma_a;
      bus.bus_wdata  = bus.dma_wdata;
      bus.bus_mem_we = bus.dma_we & !bus.dma_io;
      bus.bus_io_we  = bus.dma_we & bus.dma_io;
      bus.bus_io_sel = bus.dma_io;
    end else begin
      bus.bus_a      = bus.cpu_a;
      bus.bus_wdata  = bus.cpu_do;
      bus.bus_mem_we = !bus.cpu_mreq_n & !bus.cpu_wr_n;
      bus.bus_io_we  = !bus.cpu_iorq_n & !bus.cpu_wr_n;
      bus.bus_io_sel = !bus.cpu_iorq_n;
    end
    if (reset || (state_q == S_REL)) begin
      bus.bus_mem_we = 1'b0;
      bus.bus_io_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_tv80_bus_arbiter.sv
// Bench for tv80_bus_arbiter: directed handshake scenarios followed by random traffic,
// all outputs compared each cycle against a rule-level model of the bus ownership protocol.
module tb_tv80_bus_arbiter;
  localparam int unsigned MB = 4;
  localparam int unsigned HO = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tv80_bus_arbiter_if bus ();
  tv80_bus_arbiter #(.MAX_BURST(MB), .HOLDOFF(HO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  // Memory and IO space seen by the muxed bus, written on the falling edge.
  logic [7:0]  mem [0:65535];
  int unsigned mem_wr_cnt = 0;
  int unsigned io_wr_cnt  = 0;
  always @(negedge clk) begin
    if (bus.bus_mem_we) begin
      mem[bus.bus_a] <= bus.bus_wdata;
      mem_wr_cnt     <= mem_wr_cnt + 1;
    end
    if (bus.bus_io_we) io_wr_cnt <= io_wr_cnt + 1;
  end

  // Ownership model: who holds the bus, whether a request is pending, and whether it is being handed back.
  bit          m_busrq_n = 1'b1;
  bit          m_gnt     = 1'b0;
  bit          m_rel     = 1'b0;
  bit          m_abort   = 1'b0;
  bit          m_forced  = 1'b0;
  int unsigned m_hold    = 0;
  int unsigned m_tenure  = 0;

  bit          auto_ack  = 1'b1;
  int unsigned ack_wait  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_abort = 1'b0;
    if (reset) begin
      m_busrq_n = 1'b1; m_gnt = 1'b0; m_rel = 1'b0;
      m_forced  = 1'b0; m_hold = 0;   m_tenure = 0;
    end else if (m_gnt) begin
      m_tenure++;
      if (!bus.dma_req) begin
        m_gnt = 1'b0; m_busrq_n = 1'b1; m_rel = 1'b1;
      end
`ifdef BUSARB_BURST_LIMIT_EN
      else if (m_tenure == MB) begin
        m_gnt = 1'b0; m_busrq_n = 1'b1; m_rel = 1'b1;
        m_forced = 1'b1; m_abort = 1'b1;
      end
`endif
    end else if (!m_busrq_n) begin
      if (!bus.dma_req) begin
        m_busrq_n = 1'b1; m_rel = 1'b1;
      end else if (!bus.cpu_busak_n) begin
        m_gnt = 1'b1; m_tenure = 0;
      end
    end else if (m_rel) begin
      if (bus.cpu_busak_n) begin
        m_rel = 1'b0;
        if (m_forced) begin
          m_hold   = HO;
          m_forced = 1'b0;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (bus.dma_req) begin
      m_busrq_n = 1'b0;
    end
  endtask

  task automatic check_mux();
    logic [15:0] e_a;
    logic [7:0]  e_d;
    logic        e_mem, e_io, e_sel;
    #1;
    if (m_gnt) begin
      e_a = bus.dma_a; e_d = bus.dma_wdata;
      e_mem = bus.dma_we & ~bus.dma_io; e_io = bus.dma_we & bus.dma_io; e_sel = bus.dma_io;
    end else begin
      e_a = bus.cpu_a; e_d = bus.cpu_do;
      e_mem = ~bus.cpu_mreq_n & ~bus.cpu_wr_n; e_io = ~bus.cpu_iorq_n & ~bus.cpu_wr_n;
      e_sel = ~bus.cpu_iorq_n;
    end
    if (reset || m_rel) begin
      e_mem = 1'b0; e_io = 1'b0;
    end
    check("bus_a",      bus.bus_a,      e_a);
    check("bus_wdata",  bus.bus_wdata,  e_d);
    check("bus_mem_we", bus.bus_mem_we, e_mem);
    check("bus_io_we",  bus.bus_io_we,  e_io);
    check("bus_io_sel", bus.bus_io_sel, e_sel);
  endtask

  // The CPU acknowledges or releases after a random number of cycles (end of its M-cycle).
  task automatic cpu_model();
    if (!bus.cpu_busrq_n && bus.cpu_busak_n) begin
      if (ack_wait == 0) bus.cpu_busak_n = 1'b0;
      else ack_wait--;
    end else if (bus.cpu_busrq_n && !bus.cpu_busak_n) begin
      if (ack_wait == 0) bus.cpu_busak_n = 1'b1;
      else ack_wait--;
    end else begin
      ack_wait = $urandom_range(0, 2);
    end
  endtask

  task automatic tick();
    check_mux();
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_busrq_n", bus.cpu_busrq_n, m_busrq_n);
    check("dma_gnt",     bus.dma_gnt,     m_gnt);
    check("burst_abort", bus.burst_abort, m_abort);
    if (auto_ack) cpu_model();
  endtask

  task automatic cpu_quiet();
    bus.cpu_mreq_n = 1'b1; bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1; bus.cpu_wr_n   = 1'b1;
  endtask

  initial begin
    int unsigned k;
    int unsigned wr0, io0;
    int unsigned gnt_cycles, aborts;

    bus.cpu_busak_n = 1'b1;
    bus.cpu_a = 16'h1234; bus.cpu_do = 8'h00;
    cpu_quiet();
    bus.dma_req = 1'b0; bus.dma_a = 16'h0000; bus.dma_wdata = 8'h00;
    bus.dma_we = 1'b0;  bus.dma_io = 1'b0;

    // Reset for 3 clocks with a CPU write pending: no strobe may escape.
    reset = 1'b1;
    bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0;
    repeat (3) tick();
    check("rst_busrq_n", bus.cpu_busrq_n, 1'b1);
    check("rst_gnt",     bus.dma_gnt,     1'b0);
    check("rst_mem_we",  bus.bus_mem_we,  1'b0);
    reset = 1'b0;
    cpu_quiet();
    repeat (2) tick();

    // Grant.
    bus.dma_req = 1'b1;
    tick();
    check("busrq_latency", bus.cpu_busrq_n, 1'b0);
    k = 0;
    while (!bus.dma_gnt && k < 20) begin
      tick();
      k++;
    end
    check("grant_seen", bus.dma_gnt, 1'b1);

    // DMA writes 5Ah..5Dh to 8000h..8003h while the CPU strobes are (wrongly) active.
    wr0 = mem_wr_cnt; io0 = io_wr_cnt;
    bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; bus.cpu_a = 16'h0100; bus.cpu_do = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      bus.dma_a = 16'h8000 + 16'(i); bus.dma_wdata = 8'h5A + 8'(i);
      bus.dma_we = 1'b1; bus.dma_io = 1'b0;
      tick();
    end
    bus.dma_we = 1'b0;
    cpu_quiet();
    for (int i = 0; i < 4; i++) check("dma_mem", mem[16'h8000 + 16'(i)], 8'h5A + 8'(i));
    check("dma_wr_count", mem_wr_cnt - wr0, 4);
    check("dma_io_untouched", io_wr_cnt - io0, 0);

    // Release.
    bus.dma_req = 1'b0;
    tick();
    check("rel_gnt",     bus.dma_gnt,     1'b0);
    check("rel_busrq_n", bus.cpu_busrq_n, 1'b1);
    repeat (12) tick();

    // Withdraw on the same edge the CPU acknowledges.
    auto_ack = 1'b0;
    bus.cpu_busak_n = 1'b1;
    bus.dma_req = 1'b1;
    tick();
    check("wd_busrq_low", bus.cpu_busrq_n, 1'b0);
    bus.dma_req = 1'b0; bus.cpu_busak_n = 1'b0;
    tick();
    check("wd_no_gnt",   bus.dma_gnt,     1'b0);
    check("wd_busrq_n",  bus.cpu_busrq_n, 1'b1);
    bus.cpu_busak_n = 1'b1;
    repeat (2) tick();

    // Spurious acknowledge while idle is ignored.
    bus.cpu_busak_n = 1'b0;
    repeat (2) tick();
    check("spur_gnt", bus.dma_gnt, 1'b0);
    bus.cpu_busak_n = 1'b1;
    tick();
    auto_ack = 1'b1;

`ifdef BUSARB_BURST_LIMIT_EN
    // Request held indefinitely: forced release, hold-off, then re-request.
    gnt_cycles = 0; aborts = 0;
    bus.dma_req = 1'b1;
    k = 0;
    while (aborts == 0 && k < 40) begin
      tick();
      if (bus.dma_gnt) gnt_cycles++;
      if (bus.burst_abort) aborts++;
      k++;
    end
    check("burst_gnt_cycles", gnt_cycles, MB);
    check("burst_abort_seen", aborts, 1);
    k = 0;
    while (bus.cpu_busrq_n && k < 30) begin
      tick();
      if (bus.burst_abort) aborts++;
      k++;
    end
    check("burst_rerequest", bus.cpu_busrq_n, 1'b0);
    check("burst_abort_once", aborts, 1);
    bus.dma_req = 1'b0;
    repeat (15) tick();
`else
    gnt_cycles = 0; aborts = 0;
    bus.dma_req = 1'b1;
    for (int i = 0; i < 3 * MB + 20; i++) begin
      tick();
      if (bus.dma_gnt) gnt_cycles++;
      if (bus.burst_abort) aborts++;
    end
    check("unbounded_no_abort", aborts, 0);
    check("unbounded_gnt_held", bus.dma_gnt, 1'b1);
    bus.dma_req = 1'b0;
    repeat (8) tick();
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      bus.cpu_a = 16'($urandom); bus.cpu_do = 8'($urandom);
      bus.cpu_mreq_n = 1'($urandom); bus.cpu_iorq_n = 1'($urandom);
      bus.cpu_rd_n   = 1'($urandom); bus.cpu_wr_n   = 1'($urandom);
      bus.dma_a = 16'($urandom); bus.dma_wdata = 8'($urandom);
      bus.dma_we = 1'($urandom); bus.dma_io = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bus.dma_req = ~bus.dma_req;
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tv80_bus_arbiter.md
# tv80_bus_arbiter

Shares the single memory/IO bus of the `tv80s` core between the CPU and one DMA requester (loader, video fetch, test-bench injector) using the Z80 BUSRQ/BUSAK handshake. Drives `busrq_n`, waits for `busak_n`, then switches the address/data/strobe mux to the DMA port for the tenure and hands the bus back cleanly. Sits between the `tv80s` instance and the 64 KiB memory / 256-byte IO arrays.

## Interface
Parameters:
- `MAX_BURST`, 64: max DMA-owned cycles per grant (used only with `BUSARB_BURST_LIMIT_EN`).
- `HOLDOFF`, 8: idle cycles after a forced release before re-requesting (used only with `BUSARB_BURST_LIMIT_EN`).

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- `clk` in 1: system clock, same as CPU `clk`.
- `reset` in 1: synchronous active-high reset.
- `cpu_busrq_n` out 1: to CPU `busrq_n`.
- `cpu_busak_n` in 1: from CPU `busak_n`.
- `cpu_a` in 16, `cpu_do` in 8, `cpu_mreq_n`, `cpu_iorq_n`, `cpu_rd_n`, `cpu_wr_n` in 1 each: CPU bus.
- `dma_req` in 1: level request, held high for the whole tenure.
- `dma_gnt` out 1: DMA owns the bus.
- `dma_a` in 16, `dma_wdata` in 8, `dma_we` in 1, `dma_io` in 1: DMA bus cycle (io=1 targets IO space).
- `bus_a` out 16, `bus_wdata` out 8: muxed address/write data.
- `bus_mem_we`, `bus_io_we`, `bus_io_sel` out 1: muxed write strobes and IO select for read-data mux.
- `burst_abort` out 1: one-cycle pulse when the burst limit forced release.

## Operation
- States: `CPU`, `REQ`, `DMA`, `REL`, and `HOLD` (only with the macro).
- `CPU`: mux selects CPU. `bus_mem_we = !cpu_mreq_n & !cpu_wr_n`, `bus_io_we = !cpu_iorq_n & !cpu_wr_n`, `bus_io_sel = !cpu_iorq_n`. `dma_req`=1 -> `REQ`.
- `REQ`: `cpu_busrq_n`=0 (registered). Mux still CPU. `cpu_busak_n`=0 sampled -> `DMA`. `dma_req` dropped -> `REL` (withdraw).
- `DMA`: `dma_gnt`=1, `cpu_busrq_n`=0, mux selects DMA: `bus_mem_we = dma_we & !dma_io`, `bus_io_we = dma_we & dma_io`, `bus_io_sel = dma_io`. `dma_req`=0 -> `REL`.
- `REL`: `dma_gnt`=0, `cpu_busrq_n`=1, mux selects CPU with all write strobes forced 0. `cpu_busak_n`=1 sampled -> `CPU` (or `HOLD` if the release was forced).
- The DMA mux is active only while `dma_gnt`=1; the CPU never sees write strobes from the DMA port and vice versa. `busak_n` falling outside `REQ`/`DMA` is ignored.
- Reset in any state -> `CPU` next edge. Tenure is abandoned and no write strobe is issued on the reset cycle.

## Timing
- Reset values: `cpu_busrq_n`=1, `dma_gnt`=0, `burst_abort`=0, state `CPU`, counters 0. Combinational mux outputs follow the CPU path.
- Edge 1 with `dma_req`=1 in `CPU`: `cpu_busrq_n`=0 after that edge.
- The tv80 asserts `busak_n` at the end of its current M-cycle. The first edge sampling `busak_n`=0 sets `dma_gnt`=1 the following cycle. Minimum request-to-grant latency is 2 clocks.
- DMA write: `dma_we` is sampled by memory at the negedge while `dma_gnt`=1, giving one write per clock. Read data is valid on the next negedge (memory is registered on negedge).
- Release: `dma_req` low at edge N gives `dma_gnt`=0 and `cpu_busrq_n`=1 after edge N. The state enters `CPU` on the first edge with `busak_n`=1.
- `dma_req` and `busak_n` changing on the same edge in `REQ`: withdrawal wins, go to `REL`. No grant is issued.

## Configuration
- `BUSARB_BURST_LIMIT_EN` defined: a counter increments each `DMA` cycle. Reaching `MAX_BURST` forces `REL` and pulses `burst_abort` for 1 cycle, even with `dma_req` still high. After `REL` the state goes to `HOLD` for `HOLDOFF` cycles, then to `CPU`, which re-requests if `dma_req` is still high. This guarantees CPU progress.
- Not defined: no counter and no `HOLD` state. `burst_abort` is tied 0 and tenure is unbounded.

## Test plan
- Reset: hold `reset`=1 for 3 clocks -> `cpu_busrq_n`=1, `dma_gnt`=0, `bus_a` follows `cpu_a`; CPU executes `RLCA` (07h) at 0000h with A=88h, giving A=11h, F=01h, PC=0001h.
- Grant: raise `dma_req` with the CPU running NOPs -> `cpu_busrq_n`=0 within 1 clock, `dma_gnt`=1 exactly 1 clock after `busak_n`=0, CPU PC frozen.
- DMA write: grant held, write 4 bytes 5Ah..5Dh to 8000h..8003h -> `mem[8000h..8003h]`=5Ah..5Dh, no CPU writes, IO array unchanged.
- Release: drop `dma_req` -> `dma_gnt`=0 next clock; CPU resumes at the saved PC; state `CPU` once `busak_n`=1.
- Withdraw: pulse `dma_req` for 1 clock -> `cpu_busrq_n` returns to 1 without `dma_gnt` ever asserting.
- Burst limit (macro on, `MAX_BURST`=4, `HOLDOFF`=3): hold `dma_req`=1 -> `dma_gnt` high exactly 4 cycles, then `burst_abort` pulses once, 3 idle cycles follow, then `cpu_busrq_n`=0 again.
